// File: rtl/mem_ctrl.sv
// Byte-serial RAM port arbiter for instruction fetch and the MEM stage.
// Each access is sequenced one little-endian byte per cycle; the owner gets a one-cycle ack.
module mem_ctrl #(
  parameter int ADDR_W       = 32,
  parameter bit MEM_PRIORITY = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [31:0]       if_data_o,
  input  logic              mem_req_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic              mem_wr_i,
  input  logic [1:0]        mem_cnf_i,
  input  logic              mem_signed_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_ack_o,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_stall_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i
);

  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

  state_t            state;
  logic              owner_if;
  logic [ADDR_W-1:0] base;
  logic [1:0]        last, cnt, cnt_nx;
  logic [31:0]       wdata, asm_q, word, ext;
  logic              sgn, if_ack_q;
  logic              mem_ok, if_ok, take_mem, take_if;
  logic [1:0]        mem_last;
  logic [ADDR_W-1:0] nxt_addr;

  assign mem_ok   = mem_req_i & (mem_cnf_i != 2'd0);
  assign if_ok    = if_req_i & ~flush_i;
  assign take_mem = mem_ok & (MEM_PRIORITY | ~if_ok);
  assign take_if  = if_ok & ~take_mem;
  // last byte index: B=0, H=1, W=3
  assign mem_last = (mem_cnf_i == 2'd3) ? 2'd3 : mem_cnf_i - 2'd1;
  assign cnt_nx   = cnt + 2'd1;
  assign nxt_addr = base + ADDR_W'(cnt_nx);

  // merge the byte arriving this cycle so the ack cycle already sees the full word
  always_comb begin
    word = asm_q;
    word[{cnt, 3'b000} +: 8] = ram_din_i;
  end

  always_comb begin
    case (last)
      2'd0:    ext = sgn ? {{24{word[7]}}, word[7:0]} : {24'd0, word[7:0]};
      2'd1:    ext = sgn ? {{16{word[15]}}, word[15:0]} : {16'd0, word[15:0]};
      default: ext = word;
    endcase
  end

  assign if_ack_o    = if_ack_q & ~flush_i;
  assign mem_stall_o = mem_req_i & (mem_cnf_i != 2'd0) & ~mem_ack_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      owner_if    <= 1'b0;
      base        <= '0;
      last        <= 2'd0;
      cnt         <= 2'd0;
      wdata       <= 32'd0;
      asm_q       <= 32'd0;
      sgn         <= 1'b0;
      if_ack_q    <= 1'b0;
      if_data_o   <= 32'd0;
      mem_ack_o   <= 1'b0;
      mem_rdata_o <= 32'd0;
      ram_addr_o  <= '0;
      ram_wr_o    <= 1'b0;
      ram_dout_o  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (take_mem) begin
            owner_if   <= 1'b0;
            base       <= mem_addr_i;
            ram_addr_o <= mem_addr_i;
            last       <= mem_last;
            wdata      <= mem_wdata_i;
            sgn        <= mem_signed_i;
            cnt        <= 2'd0;
            asm_q      <= 32'd0;
            if (mem_wr_i) begin
              ram_wr_o   <= 1'b1;
              ram_dout_o <= mem_wdata_i[7:0];
              state      <= MEM_WR;
            end else begin
              state      <= MEM_RD;
            end
          end else if (take_if) begin
            owner_if   <= 1'b1;
            base       <= if_addr_i;
            ram_addr_o <= if_addr_i;
            last       <= 2'd3;
            sgn        <= 1'b0;
            cnt        <= 2'd0;
            asm_q      <= 32'd0;
            state      <= IF_RD;
          end
        end
        IF_RD, MEM_RD: begin
          if (state == IF_RD && flush_i) begin
            state <= IDLE;
          end else begin
            asm_q <= word;
            if (cnt == last) begin
              state <= DONE;
              if (owner_if) begin
                if_ack_q  <= 1'b1;
                if_data_o <= word;
              end else begin
                mem_ack_o   <= 1'b1;
                mem_rdata_o <= ext;
              end
            end else begin
              cnt        <= cnt_nx;
              ram_addr_o <= nxt_addr;
            end
          end
        end
        MEM_WR: begin
          if (cnt == last) begin
            ram_wr_o  <= 1'b0;
            mem_ack_o <= 1'b1;
            state     <= DONE;
          end else begin
            cnt        <= cnt_nx;
            ram_addr_o <= nxt_addr;
            ram_dout_o <= wdata[{cnt_nx, 3'b000} +: 8];
          end
        end
        DONE: begin
          if_ack_q  <= 1'b0;
          mem_ack_o <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte-array RAM, vector table, corner sequences and a random
// load/store/fetch mix checked against a byte-level memory model.
module tb_mem_ctrl;

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic        if_req = 1'b0, mem_req = 1'b0, mem_wr = 1'b0, mem_signed = 1'b0;
  logic [31:0] if_addr = 32'd0, mem_addr = 32'd0, mem_wdata = 32'd0;
  logic [1:0]  mem_cnf = 2'd0;
  logic        if_ack, mem_ack, mem_stall, ram_wr;
  logic [31:0] if_data, mem_rdata, ram_addr;
  logic [7:0]  ram_dout, ram_din;

  int tests = 0, fails = 0;

  logic [7:0]  ram   [0:4095];
  logic [7:0]  model [0:4095];
  logic        ld_en = 1'b0;
  logic [11:0] ld_a  = 12'd0;
  int          wcnt  = 0;
  logic [31:0] wl_a  [0:255];
  logic [7:0]  wl_d  [0:255];

  mem_ctrl #(.ADDR_W(32), .MEM_PRIORITY(1'b1)) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_data_o(if_data),
    .mem_req_i(mem_req), .mem_addr_i(mem_addr), .mem_wr_i(mem_wr), .mem_cnf_i(mem_cnf),
    .mem_signed_i(mem_signed), .mem_wdata_i(mem_wdata), .mem_ack_o(mem_ack),
    .mem_rdata_o(mem_rdata), .mem_stall_o(mem_stall),
    .ram_addr_o(ram_addr), .ram_wr_o(ram_wr), .ram_dout_o(ram_dout), .ram_din_i(ram_din)
  );

  always #5 clk = ~clk;

  assign ram_din = ram[ram_addr[11:0]];

  always @(posedge clk) begin
    if (ld_en) ram[ld_a] <= model[ld_a];
    else if (ram_wr) begin
      ram[ram_addr[11:0]] <= ram_dout;
      wl_a[wcnt[7:0]]     <= ram_addr;
      wl_d[wcnt[7:0]]     <= ram_dout;
      wcnt                <= wcnt + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // little-endian gather of n bytes, then extension by plain arithmetic
  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input bit sg);
    logic [31:0] v;
    logic [31:0] ea;
    v = 32'd0;
    for (int k = 0; k < n; k++) begin
      ea = a + 32'(k);
      v = v | (32'(model[ea[11:0]]) << (8 * k));
    end
    if (sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic check_store(input string nm, input logic [31:0] a, input logic [31:0] wd,
                             input int n, input int w0);
    chk({nm, "_nwr"}, wcnt - w0, n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] ea;
      logic [7:0]  ed;
      ea = a + 32'(k);
      ed = 8'(wd >> (8 * k));
      chk($sformatf("%s_waddr%0d", nm, k), wl_a[8'(w0 + k)], ea);
      chk($sformatf("%s_wbyte%0d", nm, k), {24'd0, wl_d[8'(w0 + k)]}, {24'd0, ed});
      model[ea[11:0]] = ed;
    end
  endtask

  task automatic run_txn(input bit is_if, input bit wr, input logic [1:0] cnf, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd, input bit rf,
                         output logic [31:0] data, output int lat, output int wrs);
    lat = -1; wrs = 0; data = 32'd0;
    if (is_if) begin
      if_req = 1'b1; if_addr = a;
    end else begin
      mem_req = 1'b1; mem_addr = a; mem_wr = wr; mem_cnf = cnf;
      mem_signed = sg; mem_wdata = wd;
    end
    for (int i = 1; i <= 20; i++) begin
      if (rf) flush = 1'($urandom_range(0, 1));
      tick;
      if (ram_wr) wrs++;
      if (is_if ? if_ack : mem_ack) begin
        data = is_if ? if_data : mem_rdata;
        lat  = i;
        break;
      end
    end
    if_req = 1'b0; mem_req = 1'b0; flush = 1'b0;
    tick;
  endtask

  task automatic exec(input string nm, input bit is_if, input bit wr, input logic [1:0] cnf,
                      input bit sg, input logic [31:0] a, input logic [31:0] wd, input bit rf,
                      output logic [31:0] data);
    int n, lat, wrs, w0;
    logic [31:0] exp;
    n   = is_if ? 4 : (cnf == 2'd3 ? 4 : int'(cnf));
    exp = ref_load(a, n, is_if ? 1'b0 : sg);
    w0  = wcnt;
    run_txn(is_if, wr && !is_if, cnf, sg, a, wd, rf, data, lat, wrs);
    chk({nm, "_lat"}, lat, n + 1);
    if (wr && !is_if) begin
      chk({nm, "_wrcycles"}, wrs, n);
      check_store(nm, a, wd, n, w0);
    end else begin
      chk({nm, "_data"}, data, exp);
    end
  endtask

  typedef struct {
    bit          is_if;
    bit          wr;
    logic [1:0]  cnf;
    bit          sg;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [31:0] d, md, id;
    int mt, it, n_ack, n_wr, n_stall, w0;

    tbl[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h100, 32'h0,        32'h00A00513};
    tbl[1]  = '{1'b0, 1'b0, 2'd1, 1'b1, 32'h20,  32'h0,        32'hFFFFFF80};
    tbl[2]  = '{1'b0, 1'b0, 2'd1, 1'b0, 32'h20,  32'h0,        32'h00000080};
    tbl[3]  = '{1'b0, 1'b0, 2'd2, 1'b1, 32'h22,  32'h0,        32'hFFFF9234};
    tbl[4]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h22,  32'h0,        32'h00009234};
    tbl[5]  = '{1'b0, 1'b0, 2'd3, 1'b1, 32'h20,  32'h0,        32'h92341180};
    tbl[6]  = '{1'b0, 1'b0, 2'd1, 1'b1, 32'h21,  32'h0,        32'h00000011};
    tbl[7]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h30,  32'h123456A5, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 2'd1, 1'b1, 32'h30,  32'h0,        32'hFFFFFFA5};
    tbl[9]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h32,  32'hFFFF8001, 32'h0};
    tbl[10] = '{1'b0, 1'b0, 2'd3, 1'b0, 32'h30,  32'h0,        32'h800100A5};

    for (int i = 0; i < 4096; i++) model[i] = 8'($urandom);
    model[12'h100] = 8'h13; model[12'h101] = 8'h05; model[12'h102] = 8'hA0; model[12'h103] = 8'h00;
    model[12'h020] = 8'h80; model[12'h021] = 8'h11; model[12'h022] = 8'h34; model[12'h023] = 8'h92;
    model[12'h031] = 8'h00;

    #2 rst = 1'b0;
    #1;
    chk("rst_flags", {29'd0, if_ack, mem_ack, ram_wr}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);

    ld_en = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      ld_a = 12'(i);
      tick;
    end
    ld_en = 1'b0;
    rst = 1'b1;
    tick;

    for (int i = 0; i < 11; i++) begin
      exec($sformatf("vec%0d", i), tbl[i].is_if, tbl[i].wr, tbl[i].cnf, tbl[i].sg,
           tbl[i].addr, tbl[i].wd, 1'b0, d);
      if (!tbl[i].wr) chk($sformatf("vec%0d_tbl", i), d, tbl[i].exp);
    end

    exec("sw40", 1'b0, 1'b1, 2'd3, 1'b0, 32'h40, 32'hDEADBEEF, 1'b0, d);
    chk("sw40_addr_hold", ram_addr, 32'h43);
    chk("sw40_wr_idle", {31'd0, ram_wr}, 32'd0);

    // simultaneous requests: MEM first, IF at the first IDLE after DONE
    md = 32'd0; id = 32'd0; mt = -1; it = -1;
    mem_req = 1'b1; mem_addr = 32'h20; mem_wr = 1'b0; mem_cnf = 2'd3; mem_signed = 1'b0;
    if_req = 1'b1; if_addr = 32'h100;
    for (int i = 1; i <= 30; i++) begin
      tick;
      if (i == 1) chk("both_stall", {31'd0, mem_stall}, 32'd1);
      if (mem_ack && mt < 0) begin mt = i; md = mem_rdata; mem_req = 1'b0; end
      if (if_ack && it < 0) begin it = i; id = if_data; if_req = 1'b0; end
      if (mt >= 0 && it >= 0) break;
    end
    mem_req = 1'b0; if_req = 1'b0;
    tick;
    chk("both_mem_lat", mt, 5);
    chk("both_if_lat", it, 11);
    chk("both_mem_data", md, ref_load(32'h20, 4, 1'b0));
    chk("both_if_data", id, ref_load(32'h100, 4, 1'b0));

    // flush two cycles into a fetch, then refetch from 0x200
    if_req = 1'b1; if_addr = 32'h100;
    tick; tick;
    flush = 1'b1;
    tick;
    chk("flush_noack", {31'd0, if_ack}, 32'd0);
    flush = 1'b0; if_addr = 32'h200;
    mt = -1;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (if_ack) begin mt = i; d = if_data; break; end
    end
    if_req = 1'b0;
    tick;
    chk("flush_refetch_lat", mt, 5);
    chk("flush_refetch_data", d, ref_load(32'h200, 4, 1'b0));

    // flush in the ack cycle masks if_ack
    if_req = 1'b1; if_addr = 32'h100;
    for (int i = 0; i < 5; i++) tick;
    chk("done_ack_pre", {31'd0, if_ack}, 32'd1);
    flush = 1'b1;
    #1;
    chk("done_ack_flushed", {31'd0, if_ack}, 32'd0);
    if_req = 1'b0;
    tick;
    flush = 1'b0;

    // cnf=0 is never granted
    n_ack = 0; n_wr = 0; n_stall = 0;
    mem_req = 1'b1; mem_cnf = 2'd0; mem_wr = 1'b1; mem_addr = 32'h50;
    for (int i = 0; i < 6; i++) begin
      tick;
      n_ack += int'(mem_ack); n_wr += int'(ram_wr); n_stall += int'(mem_stall);
    end
    mem_req = 1'b0;
    tick;
    chk("cnf0_acks", n_ack, 0);
    chk("cnf0_writes", n_wr, 0);
    chk("cnf0_stall", n_stall, 0);

    exec("sw_wrap", 1'b0, 1'b1, 2'd3, 1'b0, 32'hFFFFFFFE, 32'h0A0B0C0D, 1'b0, d);

    // async reset after two store bytes
    w0 = wcnt;
    mem_req = 1'b1; mem_addr = 32'h60; mem_wr = 1'b1; mem_cnf = 2'd3; mem_wdata = 32'h11223344;
    tick; tick; tick;
    mem_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_flags", {29'd0, if_ack, mem_ack, ram_wr}, 32'd0);
    chk("midrst_ram_addr", ram_addr, 32'd0);
    chk("midrst_ram_dout", {24'd0, ram_dout}, 32'd0);
    chk("midrst_rdata", mem_rdata, 32'd0);
    tick; tick; tick;
    check_store("midrst", 32'h60, 32'h00003344, 2, w0);
    rst = 1'b1;
    tick;

    for (int i = 0; i < 40; i++) begin
      bit          r_if, r_wr, r_sg;
      logic [1:0]  r_cnf;
      r_if  = ($urandom_range(0, 3) == 0);
      r_wr  = r_if ? 1'b0 : 1'($urandom_range(0, 1));
      r_sg  = 1'($urandom_range(0, 1));
      r_cnf = 2'($urandom_range(1, 3));
      exec($sformatf("rnd%0d", i), r_if, r_wr, r_cnf, r_sg, $urandom, $urandom, !r_if, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
